btn_alu_seq: RTL and testbench
==============================

Name: btn_alu_seq

Overview:
Parametrised, clocked successor to the board's push-button ALU. Two active-low buttons drive it:
- one button steps through eight operations;
- the other executes the selected operation on two WIDTH-bit operands.

The registered result and the selected op are shown on active-low LEDs. Multiply is iterative (shift-add), so the block has a real busy/done sequence.

Parameters:
WIDTH, 4, operand/result width (>=2)
DB_CYCLES, 16, consecutive stable synchronised samples required to accept a new button level (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_op_n  in  1  raw active-low button; press advances op select
btn_exec_n  in  1  raw active-low button; press starts execution
opa  in  WIDTH  operand A, sampled at execute accept
opb  in  WIDTH  operand B, sampled at execute accept
led_n  out  WIDTH  active-low result display (~result)
led_op_n  out  3  active-low op-select display (~op_sel)
carry  out  1  carry/borrow/shift-out flag of last op
zero  out  1  last result == 0
busy  out  1  high while FSM not IDLE
done  out  1  one-cycle pulse when result register updates

Behaviour:
- Reset (async, rst=1): op_sel=0, result=0, carry=0, zero=0, busy=0, done=0, FSM=IDLE, debounced levels=1, debounce counters=0. Outputs are therefore led_n=all ones, led_op_n=3'b111. Reset mid-operation aborts immediately; no partial result is kept.
- Button path (per button):
  - 2-flop synchroniser on the raw input.
  - Counter counts consecutive cycles where the synchronised value differs from the debounced level; it clears on any match.
  - When the count reaches DB_CYCLES, the debounced level flips and the counter clears.
  - Press event = debounced 1->0 transition, a single-cycle pulse. No auto-repeat; release generates nothing.
- op_sel (3 bits):
  - Encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
  - Increments on an op press, wrapping 7->0.
  - An op press while busy=1 is ignored.
- FSM states IDLE, EXEC, MULT, DONE:
  - IDLE: on exec press, latch opa, opb, op_sel into internal registers. Go to MULT if op=7, else EXEC. Exec and op presses in the same cycle: exec uses the pre-increment op_sel, and op_sel still increments.
  - EXEC: compute and write result/carry/zero at the end of this cycle; go to DONE.
  - MULT: shift-add over exactly WIDTH cycles using a 2*WIDTH accumulator. On the last iteration, write result=product[WIDTH-1:0], carry=|product[2*WIDTH-1:WIDTH], zero=(result==0). Go to DONE.
  - DONE: done=1 for this cycle only; return to IDLE.
  - Exec presses outside IDLE are ignored; they are not queued.
- Latency (press pulse in cycle t):
  - Non-MUL: EXEC at t+1, DONE/new LEDs at t+2.
  - MUL: MULT at t+1..t+WIDTH, DONE at t+WIDTH+1.
- busy=1 in EXEC, MULT and DONE.
- Arithmetic and carry rules:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: result = A-B mod 2^WIDTH; carry = borrow (A<B).
  - AND/OR/XOR: carry=0.
  - SHL: result = A<<1, carry = A[MSB].
  - SHR: logical shift, result = A>>1, carry = A[0].
  - opb is unused for SHL/SHR.
- The result, carry and zero registers hold their values until the next DONE.

Optional Feature:
Macro ALU_OVF_EN.
- Defined: adds output port ovf (1 bit), which is registered alongside carry.
  - ovf = signed two's-complement overflow for ADD/SUB; 0 for all other ops.
  - Reset value 0.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4, DB_CYCLES=4; assert rst -> led_n=4'hF, led_op_n=3'b111, busy=0, done=0, carry=0, zero=0.
2. opa=2, opb=3, op=ADD, exec press at t -> done at t+2; led_n=4'hA (result 5), carry=0, zero=0.
3. Press op once (SUB); opa=2, opb=3, exec -> result 4'hF (led_n=0), carry=1; with ALU_OVF_EN ovf=0. Then opa=7, opb=1, op=ADD -> result 8, ovf=1.
4. op=MUL, opa=7, opb=5, exec -> busy for cycles t+1..t+5, done at t+5; result 4'h3, carry=1. A second exec press during MULT is ignored.
5. btn_op_n low for 2 cycles then high (bounce shorter than DB_CYCLES) -> op_sel unchanged. Eight clean presses -> op_sel wraps back to its initial value, led_op_n unchanged.
6. rst pulsed during MULT (e.g. cycle t+2) -> immediately busy=0, led_n=4'hF, op_sel=0. After release, a new ADD 1+1 gives result 2 at t'+2.

Source files
------------

// File: rtl/btn_alu_seq.sv
`default_nettype none
// =============================================================================
// Module   : btn_alu_seq
// Brief    : Push-button ALU: debounced op-select/execute buttons, 8 ops with
//            iterative shift-add multiply. Macro ALU_OVF_EN adds port ovf.
// Revision : 1.0 - initial release
// =============================================================================
module btn_alu_seq #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_op_n,
  input  logic             btn_exec_n,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] led_n,
  output logic [2:0]       led_op_n,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW  = $clog2(DB_CYCLES + 1);
  localparam int MW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [CW-1:0] C_DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [MW-1:0] C_ITER_LAST = MW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MULT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Button index 0 = op select, 1 = execute.
  logic [1:0] w_raw_n;
  logic [1:0] w_press;

  assign w_raw_n = {btn_exec_n, btn_op_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= 2'b11;
        r_level <= 1'b1;
        r_cnt   <= '0;
        r_press <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw_n[gi]};
        r_press <= 1'b0;
        if (r_sync[1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_DB_LAST) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
          // Only a high-to-low flip of the accepted level is a press.
          r_press <= r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  logic [1:0]         r_state;
  logic [2:0]         r_op_sel;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_zero;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [MW-1:0]      r_iter;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  // Extra top bit of the widened difference is the borrow (A < B).
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
      end
      OP_AND: w_alu_res = r_a & r_b;
      OP_OR:  w_alu_res = r_a | r_b;
      OP_XOR: w_alu_res = r_a ^ r_b;
      OP_SHL: begin
        w_alu_res   = {r_a[WIDTH-2:0], 1'b0};
        w_alu_carry = r_a[MSB];
      end
      OP_SHR: begin
        w_alu_res   = {1'b0, r_a[WIDTH-1:1]};
        w_alu_carry = r_a[0];
      end
      default: begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
      end
    endcase
  end

`ifdef ALU_OVF_EN
  logic w_alu_ovf;
  logic r_ovf;

  always_comb begin
    w_alu_ovf = 1'b0;
    if (r_op == OP_ADD) begin
      w_alu_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
    end else if (r_op == OP_SUB) begin
      w_alu_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op_sel <= 3'd0;
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_iter   <= '0;
`ifdef ALU_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      // Op presses are honoured only while idle, even alongside an exec press.
      if (w_press[0] && (r_state == ST_IDLE)) begin
        r_op_sel <= r_op_sel + 3'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_press[1]) begin
            r_a      <= opa;
            r_b      <= opb;
            r_op     <= r_op_sel;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, opa};
            r_mplier <= opb;
            r_iter   <= '0;
            r_state  <= (r_op_sel == OP_MUL) ? ST_MULT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_alu_res;
          r_carry  <= w_alu_carry;
          r_zero   <= (w_alu_res == '0);
`ifdef ALU_OVF_EN
          r_ovf    <= w_alu_ovf;
`endif
          r_state  <= ST_DONE;
        end
        ST_MULT: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_iter   <= r_iter + 1'b1;
          if (r_iter == C_ITER_LAST) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
`ifdef ALU_OVF_EN
            r_ovf    <= 1'b0;
`endif
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign led_n    = ~r_result;
  assign led_op_n = ~r_op_sel;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_btn_alu_seq.sv
`default_nettype none
// Testbench for btn_alu_seq: directed and randomized button sequences checked
// against an arithmetic reference model.
module tb_btn_alu_seq;

  localparam int W     = 4;
  localparam int DB    = 4;
  localparam int HOLD  = DB + 6;
  localparam int BOUND = 60;

  logic         clk = 1'b0;
  logic         rst;
  logic         btn_op_n;
  logic         btn_exec_n;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W-1:0] led_n;
  logic [2:0]   led_op_n;
  logic         carry;
  logic         zero;
  logic         busy;
  logic         done;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  btn_alu_seq #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_op_n  (btn_op_n),
    .btn_exec_n(btn_exec_n),
    .opa       (opa),
    .opb       (opb),
    .led_n     (led_n),
    .led_op_n  (led_op_n),
    .carry     (carry),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
`ifdef ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int total  = 0;
  int passed = 0;
  int exp_op = 0;
  int k_cyc  = 0;
  int op_at  = -1;

  // Reference ALU from plain integer arithmetic on the operand values.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output bit c, output bit v);
    int m;
    int sa;
    int sb;
    int s;
    m   = 1 << W;
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    res = 0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      0: begin
        s = a + b; res = s % m; c = (s >= m);
        s = sa + sb; v = (s > m / 2 - 1) || (s < -(m / 2));
      end
      1: begin
        res = (a - b + m) % m; c = (a < b);
        s = sa - sb; v = (s > m / 2 - 1) || (s < -(m / 2));
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * 2) % m; c = (a >= m / 2); end
      6: begin res = a / 2; c = (a % 2) == 1; end
      default: begin s = a * b; res = s % m; c = (s >= m); end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    k_cyc++;
    if (k_cyc == op_at) btn_op_n = 1'b0;
  endtask

  task automatic press_op();
    btn_op_n = 1'b0;
    repeat (HOLD) tick();
    btn_op_n = 1'b1;
    repeat (HOLD) tick();
    exp_op = (exp_op + 1) % 8;
  endtask

  task automatic set_op(input int target);
    while (exp_op != target) press_op();
  endtask

  // off: -1 no op press; 0 op press together with exec; n>0 op press n cycles later.
  task automatic run_exec(input int a, input int b, input int off, input string tag);
    int           op_used;
    int           res;
    int           lat;
    int           exp_lat;
    bit           c;
    bit           v;
    bit           seen;
    logic [W-1:0] er;
    logic [2:0]   eo;
    op_used = exp_op;
    model(op_used, a, b, res, c, v);
    er = W'(res);
    opa = W'(a);
    opb = W'(b);
    k_cyc = 0;
    op_at = off;
    btn_exec_n = 1'b0;
    if (off == 0) btn_op_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < BOUND && !seen; i++) begin
      tick();
      seen = (busy === 1'b1);
    end
    total++;
    if (!seen) $display("FAIL %s_start: busy never rose within %0d cycles", tag, BOUND);
    else passed++;
    // Operands were latched at accept; later changes must not matter.
    opa = W'($urandom);
    opb = W'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < BOUND) begin
      tick();
      lat++;
    end
    exp_lat = (op_used == 7) ? W : 1;
    total++;
    if (lat !== exp_lat) $display("FAIL %s_latency: busy->done %0d cycles, expected %0d", tag, lat, exp_lat);
    else passed++;
    total++;
    if (led_n !== ~er) $display("FAIL %s_led: led_n=%h expected %h (op %0d a=%0d b=%0d)", tag, led_n, ~er, op_used, a, b);
    else passed++;
    total++;
    if (carry !== c) $display("FAIL %s_carry: carry=%b expected %b", tag, carry, c);
    else passed++;
    total++;
    if (zero !== (res == 0)) $display("FAIL %s_zero: zero=%b expected %b", tag, zero, (res == 0));
    else passed++;
`ifdef ALU_OVF_EN
    total++;
    if (ovf !== v) $display("FAIL %s_ovf: ovf=%b expected %b", tag, ovf, v);
    else passed++;
`endif
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_pulse: done=%b busy=%b expected 0 0", tag, done, busy);
    else passed++;
    btn_exec_n = 1'b1;
    btn_op_n = 1'b1;
    op_at = -1;
    repeat (HOLD) tick();
    if (off == 0) exp_op = (exp_op + 1) % 8;
    eo = 3'(exp_op);
    total++;
    if (led_op_n !== ~eo) $display("FAIL %s_opsel: led_op_n=%b expected %b", tag, led_op_n, ~eo);
    else passed++;
    total++;
    if (led_n !== ~er || done !== 1'b0) $display("FAIL %s_hold: led_n=%h done=%b expected %h 0", tag, led_n, done, ~er);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_op_n = 1'b1;
    btn_exec_n = 1'b1;
    opa = '0;
    opb = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_op = 0;
    total++;
    if (led_n !== 4'hF) $display("FAIL reset_led: led_n=%h expected f", led_n);
    else passed++;
    total++;
    if (led_op_n !== 3'b111) $display("FAIL reset_opsel: led_op_n=%b expected 111", led_op_n);
    else passed++;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy: busy=%b done=%b expected 0 0", busy, done);
    else passed++;
    total++;
    if (carry !== 1'b0 || zero !== 1'b0) $display("FAIL reset_flags: carry=%b zero=%b expected 0 0", carry, zero);
    else passed++;
`ifdef ALU_OVF_EN
    total++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: ovf=%b expected 0", ovf);
    else passed++;
`endif
  endtask

  task automatic test_add_sub();
    set_op(0);
    run_exec(2, 3, -1, "add");
    set_op(1);
    run_exec(2, 3, -1, "sub");
    set_op(0);
    run_exec(7, 1, -1, "add_ovf");
  endtask

  task automatic test_mul();
    set_op(7);
    // Op press lands two cycles into the multiply and must be ignored.
    run_exec(7, 5, 2, "mul");
  endtask

  task automatic test_back_to_back();
    // Exec and op pressed in the same cycle: MUL runs, op_sel still wraps to 0.
    set_op(7);
    run_exec(3, 6, 0, "same_cycle");
    run_exec(9, 9, -1, "after_same");
  endtask

  task automatic test_bounce_wrap();
    logic [2:0] eo0;
    eo0 = 3'(exp_op);
    btn_op_n = 1'b0;
    tick();
    tick();
    btn_op_n = 1'b1;
    repeat (HOLD) tick();
    total++;
    if (led_op_n !== ~eo0) $display("FAIL bounce: led_op_n=%b expected %b", led_op_n, ~eo0);
    else passed++;
    repeat (8) press_op();
    total++;
    if (led_op_n !== ~eo0) $display("FAIL wrap: led_op_n=%b expected %b", led_op_n, ~eo0);
    else passed++;
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(0, 7);
      repeat (n) press_op();
      run_exec($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1), -1, "rand");
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    set_op(7);
    opa = 4'd7;
    opb = 4'd5;
    btn_exec_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < BOUND && !seen; i++) begin
      tick();
      seen = (busy === 1'b1);
    end
    total++;
    if (!seen) $display("FAIL rstmul_start: busy never rose within %0d cycles", BOUND);
    else passed++;
    tick();
    rst = 1'b1;
    btn_exec_n = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmul_busy: busy=%b done=%b expected 0 0", busy, done);
    else passed++;
    total++;
    if (led_n !== 4'hF || led_op_n !== 3'b111) $display("FAIL rstmul_leds: led_n=%h led_op_n=%b expected f 111", led_n, led_op_n);
    else passed++;
    repeat (3) tick();
    rst = 1'b0;
    exp_op = 0;
    repeat (HOLD) tick();
    run_exec(1, 1, -1, "add_after_rst");
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_bounce_wrap();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
